id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode-stage register file.
- Captures decode operands, immediate, register specifiers and control, and forwards them to execute.
- Detects load-use hazards and inserts a bubble, applying flush on taken branches.
- Bypasses a same-cycle writeback into the captured operands, because the register file updates only on the clock edge.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_AW, 5, register specifier width
CNT_W, 16, width of bubble performance counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low (0 = reset)
id_valid  in  1  decode holds a real instruction
id_pc4  in  DATA_W  PC+4 of decode instruction
id_a  in  DATA_W  operand A from register file
id_b  in  DATA_W  operand B from register file
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_AW each  register specifiers
id_regwrite, id_memtoreg, id_memread, id_memwrite, id_branch, id_alusrc, id_regdst  in  1 each  control
id_aluop  in  2  ALU op class
wb_regwrite  in  1  writeback writing this cycle
wb_rd  in  REG_AW  writeback destination
wb_data  in  DATA_W  writeback value
flush  in  1  taken branch resolved downstream; kill decode instruction
ex_valid  out  1  execute holds a real instruction
ex_pc4, ex_a, ex_b, ex_imm  out  DATA_W  registered copies
ex_rs, ex_rt, ex_rd  out  REG_AW  registered copies
ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_branch, ex_alusrc, ex_regdst  out  1  registered control
ex_aluop  out  2  registered control
hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
bubble_count  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (reset==0, asynchronous): every ex_* output = 0, ex_valid = 0, bubble_count = 0.
  - Outputs stay 0 while reset is held.
  - First capture occurs on the first rising edge after release.
- use_rt = ~id_alusrc | id_memwrite | id_branch.
- hazard_stall = ex_valid & ex_memread & (ex_rt != 0) & id_valid & ~flush & ((ex_rt == id_rs) | (use_rt & ex_rt == id_rt)).
- Bypass (combinational, before capture):
  - a_in = wb_data if wb_regwrite & wb_rd != 0 & wb_rd == id_rs, else id_a.
  - b_in = same test against id_rt, else id_b.
  - rd == 0 is never bypassed.
- Rising-edge priority, highest first:
  1. flush = 1: load bubble.
  2. hazard_stall = 1: load bubble.
  3. id_valid = 0: load bubble, but bubble_count is not incremented.
  4. Otherwise: load all id_* fields, with a_in/b_in in place of id_a/id_b; ex_valid = 1.
- Bubble contents: ex_valid = 0; all control outputs (regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst, aluop) = 0; data and specifier outputs = 0.
- bubble_count:
  - Increments by 1 on each edge taking case 1 or 2.
  - Saturates at all-ones; never wraps.
- Latency: one cycle from id_* to ex_*.
- Stall behaviour:
  - While stalled, upstream holds the decode instruction, so it is captured the edge after hazard_stall falls.
  - A single load-use produces exactly one bubble, because the bubble clears ex_memread.
- Simultaneous flush and hazard: flush wins; hazard_stall is forced 0 so upstream is not frozen.
- ex_rt == 0 never stalls.
- Reset asserted mid-stall: ex_* clear immediately; hazard_stall drops to 0 as ex_valid = 0.

Test Plan:
- Reset: drive reset=0 with random id_* -> all ex_* = 0, bubble_count = 0; release, id_valid=1, id_a=32'h1234 -> ex_a=32'h1234, ex_valid=1 after one edge.
- Load-use: ex holds lw with ex_rt=5; decode add with id_rs=5 -> hazard_stall=1 for one cycle; next edge ex_valid=0, ex_memread=0, bubble_count=1; following edge add captured, ex_valid=1.
- No false stall:
  - lw ex_rt=0 with id_rs=0 -> hazard_stall=0.
  - lw ex_rt=7, decode addi (alusrc=1) with id_rt=7 -> hazard_stall=0.
  - Same with sw (memwrite=1) -> hazard_stall=1.
- Bypass: wb_regwrite=1, wb_rd=9, wb_data=32'hDEAD_BEEF, id_rs=9, id_a=32'h0 -> ex_a=32'hDEAD_BEEF; repeat with wb_rd=0 -> ex_a=id_a.
- Flush priority: flush=1 during an active load-use hazard -> hazard_stall=0; next edge ex_valid=0, all control 0; bubble_count +1.
- Saturation: preload via CNT_W=2, force 5 bubbles -> bubble_count stays 2'b11.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register. It captures the decode-stage operands, immediate,
//   register specifiers and control, and presents them to execute one cycle
//   later. It also:
//     - detects a load-use hazard against the load currently in execute, and
//       inserts a bubble while asking upstream to freeze (hazard_stall);
//     - inserts a bubble when a taken branch downstream requests a flush;
//     - bypasses a same-cycle writeback into the captured operands, because
//       the register file only updates on the clock edge;
//     - keeps a saturating count of inserted bubbles (flush or hazard).
//
// Ports
//   clk, reset         clock (rising edge) and async active-low reset
//   id_*               decode-stage instruction fields and control
//   wb_regwrite/rd/data  writeback port, used for same-cycle bypass
//   flush              kill the decode instruction
//   ex_*               registered copies presented to execute
//   hazard_stall       combinational; freeze PC and IF/ID this cycle
//   bubble_count       saturating count of counted bubbles
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic [1:0]        id_aluop,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_alusrc,
    output logic              ex_regdst,
    output logic [1:0]        ex_aluop,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              use_rt;
    logic              a_byp;
    logic              b_byp;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              count_bubble;
    logic              load_bubble;

    // rt is only a true source when the ALU reads it, or a store/branch uses it.
    assign use_rt = ~id_alusrc | id_memwrite | id_branch;

    // Flush masks the stall so upstream is not frozen while being killed.
    assign hazard_stall = ex_valid & ex_memread & (ex_rt != '0) & id_valid & ~flush &
                          ((ex_rt == id_rs) | (use_rt & (ex_rt == id_rt)));

    // Register 0 is hard-wired, so a writeback to it is never forwarded.
    assign a_byp = wb_regwrite & (wb_rd != '0) & (wb_rd == id_rs);
    assign b_byp = wb_regwrite & (wb_rd != '0) & (wb_rd == id_rt);
    assign a_in  = a_byp ? wb_data : id_a;
    assign b_in  = b_byp ? wb_data : id_b;

    // An empty decode slot still loads a bubble but is not a counted one.
    assign count_bubble = flush | hazard_stall;
    assign load_bubble  = count_bubble | ~id_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_pc4      <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_aluop    <= '0;
        end else if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc4      <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_aluop    <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc4      <= id_pc4;
            ex_a        <= a_in;
            ex_b        <= b_in;
            ex_imm      <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_regwrite <= id_regwrite;
            ex_memtoreg <= id_memtoreg;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_branch   <= id_branch;
            ex_alusrc   <= id_alusrc;
            ex_regdst   <= id_regdst;
            ex_aluop    <= id_aluop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_count <= '0;
        end else if (count_bubble && (bubble_count != '1)) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4, id_a, id_b, id_imm;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              id_regwrite, id_memtoreg, id_memread, id_memwrite;
    logic              id_branch, id_alusrc, id_regdst;
    logic [1:0]        id_aluop;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4, ex_a, ex_b, ex_imm;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic              ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;
    logic              ex_branch, ex_alusrc, ex_regdst;
    logic [1:0]        ex_aluop;
    logic              hazard_stall;
    logic [CNT_W-1:0]  bubble_count;

    int n_pass  = 0;
    int n_total = 0;
    logic [CNT_W-1:0] exp_bub = '0;

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_branch(id_branch), .id_alusrc(id_alusrc),
        .id_regdst(id_regdst), .id_aluop(id_aluop),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_alusrc(ex_alusrc),
        .ex_regdst(ex_regdst), .ex_aluop(ex_aluop),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc4 = 0; id_a = 0; id_b = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_regwrite = 0; id_memtoreg = 0; id_memread = 0; id_memwrite = 0;
        id_branch = 0; id_alusrc = 0; id_regdst = 0; id_aluop = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0; flush = 0;
    endtask

    task automatic drive_lw(input logic [REG_AW-1:0] rt);
        clear_id();
        id_valid = 1; id_memread = 1; id_memtoreg = 1; id_regwrite = 1;
        id_alusrc = 1; id_rs = 5'd1; id_rt = rt; id_imm = 32'h10;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_id();
        id_valid = 1; id_pc4 = $urandom; id_a = $urandom; id_b = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_regwrite = 1; id_memread = 1; id_aluop = 2'b11;
        #2;
        step(); step();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", ex_valid); else n_pass++;
        n_total++; if ({ex_a, ex_b, ex_pc4, ex_imm} !== '0) $display("FAIL reset_data got %h exp 0", {ex_a, ex_b, ex_pc4, ex_imm}); else n_pass++;
        n_total++; if ({ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, ex_aluop} !== '0) $display("FAIL reset_ctrl got %h exp 0", {ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, ex_aluop}); else n_pass++;
        n_total++; if (bubble_count !== 2'd0) $display("FAIL reset_count got %0d exp 0", bubble_count); else n_pass++;
        reset = 1;
        clear_id();
        id_valid = 1; id_a = 32'h1234;
        step();
        n_total++; if (ex_a !== 32'h1234) $display("FAIL first_capture_a got %h exp 00001234", ex_a); else n_pass++;
        n_total++; if (ex_valid !== 1'b1) $display("FAIL first_capture_valid got %b exp 1", ex_valid); else n_pass++;
        exp_bub = 0;
    endtask

    task automatic test_load_use();
        drive_lw(5'd5);
        #1;
        n_total++; if (hazard_stall !== 1'b0) $display("FAIL lu_pre_stall got %b exp 0", hazard_stall); else n_pass++;
        step();
        n_total++; if (ex_memread !== 1'b1 || ex_rt !== 5'd5) $display("FAIL lu_lw_capture got memread=%b rt=%0d exp 1/5", ex_memread, ex_rt); else n_pass++;
        clear_id();
        id_valid = 1; id_rs = 5'd5; id_rt = 5'd2; id_rd = 5'd3;
        id_regwrite = 1; id_regdst = 1; id_aluop = 2'b10;
        #1;
        n_total++; if (hazard_stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", hazard_stall); else n_pass++;
        step();
        exp_bub = 2'd1;
        n_total++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0) $display("FAIL lu_bubble got valid=%b memread=%b exp 0/0", ex_valid, ex_memread); else n_pass++;
        n_total++; if (bubble_count !== exp_bub) $display("FAIL lu_count got %0d exp %0d", bubble_count, exp_bub); else n_pass++;
        n_total++; if (hazard_stall !== 1'b0) $display("FAIL lu_stall_drop got %b exp 0", hazard_stall); else n_pass++;
        step();
        n_total++; if (ex_valid !== 1'b1 || ex_rs !== 5'd5 || ex_rd !== 5'd3 || ex_aluop !== 2'b10) $display("FAIL lu_add_capture got valid=%b rs=%0d rd=%0d aluop=%b exp 1/5/3/10", ex_valid, ex_rs, ex_rd, ex_aluop); else n_pass++;
        n_total++; if (bubble_count !== exp_bub) $display("FAIL lu_count_hold got %0d exp %0d", bubble_count, exp_bub); else n_pass++;
    endtask

    task automatic test_no_false_stall();
        drive_lw(5'd0);
        step();
        clear_id();
        id_valid = 1; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        n_total++; if (hazard_stall !== 1'b0) $display("FAIL nfs_rt0 got %b exp 0", hazard_stall); else n_pass++;
        drive_lw(5'd7);
        step();
        n_total++; if (ex_rt !== 5'd7 || ex_memread !== 1'b1) $display("FAIL nfs_lw7 got rt=%0d memread=%b exp 7/1", ex_rt, ex_memread); else n_pass++;
        clear_id();
        id_valid = 1; id_alusrc = 1; id_rs = 5'd2; id_rt = 5'd7; id_regwrite = 1;
        #1;
        n_total++; if (hazard_stall !== 1'b0) $display("FAIL nfs_addi got %b exp 0", hazard_stall); else n_pass++;
        id_regwrite = 0; id_memwrite = 1;
        #1;
        n_total++; if (hazard_stall !== 1'b1) $display("FAIL nfs_sw got %b exp 1", hazard_stall); else n_pass++;
        id_valid = 0;
        #1;
        n_total++; if (hazard_stall !== 1'b0) $display("FAIL nfs_invalid got %b exp 0", hazard_stall); else n_pass++;
        step();
        n_total++; if (ex_valid !== 1'b0 || ex_memwrite !== 1'b0) $display("FAIL nfs_empty_slot got valid=%b memwrite=%b exp 0/0", ex_valid, ex_memwrite); else n_pass++;
        n_total++; if (bubble_count !== exp_bub) $display("FAIL nfs_count got %0d exp %0d", bubble_count, exp_bub); else n_pass++;
    endtask

    task automatic test_bypass();
        clear_id();
        id_valid = 1; id_rs = 5'd9; id_a = 32'h0; id_rt = 5'd4; id_b = 32'h55;
        wb_regwrite = 1; wb_rd = 5'd9; wb_data = 32'hDEAD_BEEF;
        step();
        n_total++; if (ex_a !== 32'hDEAD_BEEF || ex_b !== 32'h55) $display("FAIL byp_a got a=%h b=%h exp deadbeef/00000055", ex_a, ex_b); else n_pass++;
        id_rs = 5'd3; id_a = 32'h11; id_rt = 5'd9; id_b = 32'h0;
        step();
        n_total++; if (ex_a !== 32'h11 || ex_b !== 32'hDEAD_BEEF) $display("FAIL byp_b got a=%h b=%h exp 00000011/deadbeef", ex_a, ex_b); else n_pass++;
        wb_rd = 5'd0; id_rs = 5'd0; id_a = 32'hABC; id_rt = 5'd0; id_b = 32'h0;
        step();
        n_total++; if (ex_a !== 32'hABC || ex_b !== 32'h0) $display("FAIL byp_rd0 got a=%h b=%h exp 00000abc/00000000", ex_a, ex_b); else n_pass++;
        wb_regwrite = 0; wb_rd = 5'd9; id_rs = 5'd9; id_a = 32'h77;
        step();
        n_total++; if (ex_a !== 32'h77) $display("FAIL byp_nowrite got %h exp 00000077", ex_a); else n_pass++;
        clear_id();
    endtask

    task automatic test_flush();
        drive_lw(5'd6);
        step();
        clear_id();
        id_valid = 1; id_rs = 5'd6; id_rt = 5'd6; id_rd = 5'd8; id_a = 32'h99; id_b = 32'h98;
        id_pc4 = 32'h8; id_imm = 32'h5; id_regwrite = 1; id_memtoreg = 1; id_memwrite = 1;
        id_branch = 1; id_alusrc = 1; id_regdst = 1; id_aluop = 2'b11;
        #1;
        n_total++; if (hazard_stall !== 1'b1) $display("FAIL fl_hazard_pre got %b exp 1", hazard_stall); else n_pass++;
        flush = 1;
        #1;
        n_total++; if (hazard_stall !== 1'b0) $display("FAIL fl_mask got %b exp 0", hazard_stall); else n_pass++;
        step();
        exp_bub = (exp_bub == '1) ? exp_bub : exp_bub + 2'd1;
        n_total++; if (ex_valid !== 1'b0) $display("FAIL fl_valid got %b exp 0", ex_valid); else n_pass++;
        n_total++; if ({ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_branch, ex_alusrc, ex_regdst, ex_aluop} !== 9'd0)
            $display("FAIL fl_ctrl got %b exp 0", {ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_branch, ex_alusrc, ex_regdst, ex_aluop}); else n_pass++;
        n_total++; if ({ex_a, ex_b, ex_pc4, ex_imm, ex_rs, ex_rt, ex_rd} !== '0) $display("FAIL fl_data got %h exp 0", {ex_a, ex_b, ex_pc4, ex_imm, ex_rs, ex_rt, ex_rd}); else n_pass++;
        n_total++; if (bubble_count !== exp_bub) $display("FAIL fl_count got %0d exp %0d", bubble_count, exp_bub); else n_pass++;
    endtask

    task automatic test_saturation();
        flush = 1; id_valid = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_bub = (exp_bub == '1) ? exp_bub : exp_bub + 2'd1;
            n_total++; if (bubble_count !== exp_bub) $display("FAIL sat_step%0d got %0d exp %0d", i, bubble_count, exp_bub); else n_pass++;
        end
        n_total++; if (bubble_count !== 2'b11) $display("FAIL sat_final got %b exp 11", bubble_count); else n_pass++;
        clear_id();
    endtask

    task automatic test_reset_mid_stall();
        drive_lw(5'd5);
        step();
        clear_id();
        id_valid = 1; id_rs = 5'd5; id_rt = 5'd1;
        #1;
        n_total++; if (hazard_stall !== 1'b1) $display("FAIL rms_stall got %b exp 1", hazard_stall); else n_pass++;
        #2 reset = 0;
        #1;
        n_total++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_rt !== 5'd0) $display("FAIL rms_clear got valid=%b memread=%b rt=%0d exp 0/0/0", ex_valid, ex_memread, ex_rt); else n_pass++;
        n_total++; if (hazard_stall !== 1'b0) $display("FAIL rms_stall_drop got %b exp 0", hazard_stall); else n_pass++;
        n_total++; if (bubble_count !== 2'd0) $display("FAIL rms_count got %0d exp 0", bubble_count); else n_pass++;
        step();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL rms_hold got %b exp 0", ex_valid); else n_pass++;
        reset = 1;
        exp_bub = 0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_pc;
        logic [REG_AW-1:0] exp_rd;
        clear_id();
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h100 + 32'(i * 4);
            exp_rd = 5'(i + 10);
            id_valid = 1; id_pc4 = exp_pc; id_rd = exp_rd; id_regwrite = 1;
            step();
            n_total++; if (ex_pc4 !== exp_pc || ex_rd !== exp_rd || ex_valid !== 1'b1) $display("FAIL b2b_%0d got pc4=%h rd=%0d valid=%b exp %h/%0d/1", i, ex_pc4, ex_rd, ex_valid, exp_pc, exp_rd); else n_pass++;
        end
        n_total++; if (bubble_count !== exp_bub) $display("FAIL b2b_count got %0d exp %0d", bubble_count, exp_bub); else n_pass++;
        clear_id();
    endtask

    initial begin
        reset = 0;
        clear_id();
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_bypass();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
